// File: rtl/interp_param.sv
// interp_param: ZOH / linear sample-rate interpolator, one output per clock, R = 2^RATIO_LOG2 clocks per input sample
//   clock, reset (sync, active-low)
//   mode        0 = ZOH, 1 = linear; taken at segment boundaries
//   clr_flags   clears underrun/overrun (a same-cycle set wins)
//   in_valid/in_data/in_ready   sample input through a 1-deep holding register
//   out_data/out_valid/seg_start   registered output, seg_start marks phase 0
//   underrun/overrun   sticky error flags
module interp_param #(
  parameter int WIDTH      = 20,
  parameter int RATIO_LOG2 = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             clr_flags,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             seg_start,
  output logic             underrun,
  output logic             overrun
);
  localparam int L  = RATIO_LOG2;
  localparam int AW = WIDTH + L + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [L-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, hold_q, hold_d, out_data_q, out_data_d;
  logic [WIDTH:0] diff_q, diff_d;
  logic [AW-1:0] acc_q, acc_d;
  logic mode_q, mode_d, hold_v_q, hold_v_d;
  logic out_valid_q, seg_start_q, underrun_q, overrun_q;
  logic boundary, take;
  assign boundary  = (state_q == RUN) && (&phase_q);
  assign in_ready  = !hold_v_q || boundary;
  assign take      = in_valid && in_ready && (state_q == RUN);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign seg_start = seg_start_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  // acc holds prev*R + k*diff, so its upper WIDTH bits are the floored ramp value
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    diff_d   = diff_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    hold_d   = take ? in_data : hold_q;
    hold_v_d = take || (hold_v_q && !boundary);
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = RUN;
        phase_d = '0;
        prev_d  = in_data;
        cur_d   = in_data;
        diff_d  = '0;
        acc_d   = {in_data[WIDTH-1], in_data, {L{1'b0}}};
        mode_d  = mode;
      end
    end else begin
      phase_d = phase_q + L'(1);
      if (boundary) begin
        prev_d = cur_q;
        cur_d  = hold_v_q ? hold_q : cur_q;
        diff_d = hold_v_q ? {hold_q[WIDTH-1], hold_q} - {cur_q[WIDTH-1], cur_q} : '0;
        acc_d  = {cur_q[WIDTH-1], cur_q, {L{1'b0}}};
        mode_d = mode;
      end else begin
        acc_d = acc_q + {{L{diff_q[WIDTH]}}, diff_q};
      end
    end
    out_data_d = (state_d == RUN) ? (mode_d ? acc_d[AW-2:L] : cur_d) : '0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      diff_q      <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      seg_start_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      diff_q      <= diff_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= state_d == RUN;
      seg_start_q <= (state_d == RUN) && (phase_d == '0);
      underrun_q  <= (boundary && !hold_v_q) || (underrun_q && !clr_flags);
      overrun_q   <= (in_valid && !in_ready) || (overrun_q && !clr_flags);
    end
  end
endmodule

// File: tb/tb_interp_param.sv
// tb_interp_param: directed vector table plus hand sequences for interp_param (WIDTH=20, RATIO_LOG2=2)
module tb_interp_param;
  logic clock = 1'b0;
  logic reset, mode, clr_flags, in_valid, in_ready, out_valid, seg_start, underrun, overrun;
  logic [19:0] in_data, out_data;
  int checks = 0;
  int errors = 0;

  interp_param #(.WIDTH(20), .RATIO_LOG2(2)) dut (
    .clock(clock), .reset(reset), .mode(mode), .clr_flags(clr_flags),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .seg_start(seg_start),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst, v, m, clr;
    logic [19:0] d, eo;
    bit ev, es, eu, eov;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit v, logic [19:0] d, bit m, bit clr,
                              logic [19:0] eo, bit ev, bit es, bit eu, bit eov);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.m = m; x.clr = clr;
    x.eo = eo; x.ev = ev; x.es = es; x.eu = eu; x.eov = eov;
    tbl.push_back(x);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit v, logic [19:0] d, bit m, bit c);
    in_valid = v; in_data = d; mode = m; clr_flags = c;
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick; tick;
    reset = 1'b1;
    // linear ramp 0 -> 100 -> 100
    add(1,0,0,1,0,      0,0,0,0,0);
    add(0,1,0,1,0,      0,1,1,0,0);
    add(0,1,100,1,0,    0,1,0,0,0);
    add(0,0,0,1,0,      0,1,0,0,0);
    add(0,0,0,1,0,      0,1,0,0,0);
    add(0,0,0,1,0,      0,1,1,0,0);
    add(0,1,100,1,0,   25,1,0,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,0,0,1,0,     75,1,0,0,0);
    add(0,0,0,1,0,    100,1,1,0,0);
    add(0,0,0,1,0,    100,1,0,0,0);
    add(0,0,0,1,0,    100,1,0,0,0);
    add(0,0,0,1,0,    100,1,0,0,0);
    // negative ramp 0 -> -3 floors toward minus infinity
    add(1,0,0,1,0,      0,0,0,0,0);
    add(0,1,0,1,0,      0,1,1,0,0);
    add(0,1,20'hFFFFD,1,0, 0,1,0,0,0);
    add(0,0,0,1,0,      0,1,0,0,0);
    add(0,0,0,1,0,      0,1,0,0,0);
    add(0,0,0,1,0,      0,1,1,0,0);
    add(0,1,20'hFFFFD,1,0, 20'hFFFFF,1,0,0,0);
    add(0,0,0,1,0,  20'hFFFFE,1,0,0,0);
    add(0,0,0,1,0,  20'hFFFFD,1,0,0,0);
    // full-scale descent 0x7FFFF -> 0x80000
    add(1,0,0,1,0,      0,0,0,0,0);
    add(0,1,20'h7FFFF,1,0, 20'h7FFFF,1,1,0,0);
    add(0,1,20'h80000,1,0, 20'h7FFFF,1,0,0,0);
    add(0,0,0,1,0,  20'h7FFFF,1,0,0,0);
    add(0,0,0,1,0,  20'h7FFFF,1,0,0,0);
    add(0,0,0,1,0,  20'h7FFFF,1,1,0,0);
    add(0,1,20'h80000,1,0, 20'h3FFFF,1,0,0,0);
    add(0,0,0,1,0,  20'hFFFFF,1,0,0,0);
    add(0,0,0,1,0,  20'hBFFFF,1,0,0,0);
    add(0,0,0,1,0,  20'h80000,1,1,0,0);
    // ZOH, mid-segment mode toggles only take effect at a boundary, then underrun
    add(1,0,0,0,0,      0,0,0,0,0);
    add(0,1,10,0,0,    10,1,1,0,0);
    add(0,1,20,0,0,    10,1,0,0,0);
    add(0,0,0,1,0,     10,1,0,0,0);
    add(0,0,0,0,0,     10,1,0,0,0);
    add(0,0,0,0,0,     20,1,1,0,0);
    add(0,1,30,1,0,    20,1,0,0,0);
    add(0,0,0,0,0,     20,1,0,0,0);
    add(0,0,0,0,0,     20,1,0,0,0);
    add(0,0,0,1,0,     20,1,1,0,0);
    add(0,0,0,0,0,     22,1,0,0,0);
    add(0,0,0,0,0,     25,1,0,0,0);
    add(0,0,0,0,0,     27,1,0,0,0);
    add(0,0,0,0,0,     30,1,1,1,0);
    add(0,0,0,0,1,     30,1,0,0,0);
    // underrun after 50, clear, set-beats-clear, late sample used next boundary
    add(1,0,0,1,0,      0,0,0,0,0);
    add(0,1,50,1,0,    50,1,1,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,0,0,1,0,     50,1,1,1,0);
    add(0,0,0,1,1,     50,1,0,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,0,0,1,0,     50,1,0,0,0);
    add(0,1,60,1,1,    50,1,1,1,0);
    add(0,0,0,1,0,     50,1,0,1,0);
    add(0,0,0,1,0,     50,1,0,1,0);
    add(0,0,0,1,0,     50,1,0,1,0);
    add(0,0,0,1,0,     50,1,1,1,0);
    add(0,0,0,1,0,     52,1,0,1,0);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = !tbl[i].rst;
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].clr);
      tick;
      chk("out_data",  i, out_data,  tbl[i].eo);
      chk("out_valid", i, out_valid, tbl[i].ev);
      chk("seg_start", i, seg_start, tbl[i].es);
      chk("underrun",  i, underrun,  tbl[i].eu);
      chk("overrun",   i, overrun,   tbl[i].eov);
    end
    // overrun mid-segment and an accepted write in the boundary cycle
    reset = 1'b0; drive(0, 0, 0, 0); tick; reset = 1'b1;
    drive(1, 5, 0, 0); tick;
    chk("e_ir_p0", 0, in_ready, 1);
    drive(1, 7, 0, 0); tick;
    chk("e_ir_p1", 0, in_ready, 0);
    drive(1, 9, 0, 0); tick;
    chk("e_ovr_set", 0, overrun, 1);
    drive(0, 0, 0, 1); tick;
    chk("e_ovr_clr", 0, overrun, 0);
    chk("e_ir_bnd", 0, in_ready, 1);
    drive(1, 11, 0, 0); tick;
    chk("e_out7", 0, out_data, 7);
    chk("e_seg7", 0, seg_start, 1);
    chk("e_ovr_bnd", 0, overrun, 0);
    drive(0, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("e_hold7", k, out_data, 7);
    end
    tick;
    chk("e_out11", 0, out_data, 11);
    chk("e_udr11", 0, underrun, 0);
    // reset mid-ramp discards everything in flight
    reset = 1'b0; drive(0, 0, 1, 0); tick; reset = 1'b1;
    drive(1, 0, 1, 0); tick;
    drive(1, 100, 1, 0); tick;
    drive(1, 7, 1, 0); tick;
    drive(0, 0, 1, 0); tick; tick; tick; tick;
    chk("f_ramp", 0, out_data, 50);
    chk("f_ovr", 0, overrun, 1);
    reset = 1'b0; tick;
    chk("f_out", 0, out_data, 0);
    chk("f_valid", 0, out_valid, 0);
    chk("f_seg", 0, seg_start, 0);
    chk("f_udr", 0, underrun, 0);
    chk("f_ovr0", 0, overrun, 0);
    chk("f_ir", 0, in_ready, 1);
    reset = 1'b1;
    drive(1, 40, 1, 0); tick;
    chk("f_restart", 0, out_data, 40);
    chk("f_rvalid", 0, out_valid, 1);
    chk("f_rseg", 0, seg_start, 1);
    drive(0, 0, 1, 0);
    tick; tick; tick; tick;
    chk("f_empty_out", 0, out_data, 40);
    chk("f_empty_udr", 0, underrun, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
